// File: rtl/intmul_tiled_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : intmul_tiled_pipe
//  Purpose  : LOGA x LOGB integer multiplier. Both operands are cut into
//             DSP_A_U x DSP_B_U tiles, the shifted partial products are
//             summed by a registered binary adder tree, and the whole
//             datapath sits behind an elastic valid/ready pipeline that
//             carries a sideband tag. Empty stages are collapsed.
//  Options  : INTMUL_SIGNED_EN adds the 'sgn' port (1 = two's complement).
//  Revision : 1.0 - initial release
// ============================================================================
module intmul_tiled_pipe #(
    parameter int LOGA           = 34,
    parameter int LOGB           = 43,
    parameter int TAG_W          = 8,
    parameter int FF_IN          = 1,
    parameter int FF_MUL         = 1,
    parameter int ADD_LVL_PER_FF = 2,
    // Unsigned DSP multiplier port widths (same values as dsp.vh)
    parameter int DSP_A_U        = 24,
    parameter int DSP_B_U        = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LOGA-1:0]        A,
    input  logic [LOGB-1:0]        B,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef INTMUL_SIGNED_EN
    input  logic                   sgn,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LOGA+LOGB-1:0]   C,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W   = LOGA + LOGB;
    localparam int N_A = (LOGA + DSP_A_U - 1) / DSP_A_U;
    localparam int N_B = (LOGB + DSP_B_U - 1) / DSP_B_U;
    localparam int NP  = N_A * N_B;
    // A single tile still gets one (pass-through) registered tree level.
    localparam int D   = (NP > 1) ? $clog2(NP) : 1;
    localparam int S   = FF_IN + FF_MUL + (D + ADD_LVL_PER_FF - 1) / ADD_LVL_PER_FF;
    // Operands extended by at least one sign/zero bit so the top tile is signed.
    localparam int EA  = N_A * DSP_A_U + 1;
    localparam int EB  = N_B * DSP_B_U + 1;
    localparam int PW  = DSP_A_U + DSP_B_U + 2;

    // Number of nodes at tree level l (level 0 = partial products).
    function automatic int lvl_cnt(input int l);
        return (NP + (1 << l) - 1) >> l;
    endfunction

    // ------------------------------------------------------------------
    // Handshake chain: one valid bit and one tag per stage
    // ------------------------------------------------------------------
    logic [S-1:0]     valid_q;
    logic [TAG_W-1:0] tag_q  [S];
    logic [S:0]       w_load;
    logic [S-1:0]     w_vin;
    logic [S-1:0]     w_take;
    logic [TAG_W-1:0] w_tin  [S];

    for (genvar k = 0; k < S; k++) begin : g_chain
        if (k == 0) begin : g_head
            assign w_vin[k] = in_valid;
            assign w_tin[k] = in_tag;
        end else begin : g_link
            assign w_vin[k] = valid_q[k-1];
            assign w_tin[k] = tag_q[k-1];
        end
    end

    // A stage loads when empty or when its successor drains it.
    always_comb begin
        w_load    = '0;
        w_load[S] = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            w_load[k] = !valid_q[k] | w_load[k+1];
        end
    end

    assign w_take    = w_load[S-1:0] & w_vin;
    assign in_ready  = w_load[0];
    assign out_valid = valid_q[S-1];
    assign out_tag   = tag_q[S-1];

    // Valid bits and tags advance together; only the output tag is cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            tag_q[S-1]   <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (w_load[k]) valid_q[k] <= w_vin[k];
                if (w_take[k]) tag_q[k]   <= w_tin[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand stage
    // ------------------------------------------------------------------
    logic            w_sgn_in;
    logic [LOGA-1:0] w_a;
    logic [LOGB-1:0] w_b;
    logic            w_s;

`ifdef INTMUL_SIGNED_EN
    assign w_sgn_in = sgn;
`else
    assign w_sgn_in = 1'b0;
`endif

    if (FF_IN != 0) begin : g_ff_in
        logic [LOGA-1:0] a_q;
        logic [LOGB-1:0] b_q;
        logic            sgn_q;
        // Capture operands on an accepted transfer.
        always_ff @(posedge clk) begin
            if (w_take[0]) begin
                a_q   <= A;
                b_q   <= B;
                sgn_q <= w_sgn_in;
            end
        end
        assign w_a = a_q;
        assign w_b = b_q;
        assign w_s = sgn_q;
    end else begin : g_no_ff_in
        assign w_a = A;
        assign w_b = B;
        assign w_s = w_sgn_in;
    end

    // Signed mode sign-extends into the padding; unsigned mode zero-fills it.
    logic [EA-1:0]     w_ea;
    logic [EB-1:0]     w_eb;
    logic [DSP_A_U:0]  w_ta [N_A];
    logic [DSP_B_U:0]  w_tb [N_B];

    assign w_ea = {{(EA - LOGA){w_s & w_a[LOGA-1]}}, w_a};
    assign w_eb = {{(EB - LOGB){w_s & w_b[LOGB-1]}}, w_b};

    // Lower tiles are unsigned; the top tile takes the extension bit as sign.
    for (genvar i = 0; i < N_A; i++) begin : g_tile_a
        if (i == N_A - 1) begin : g_top
            assign w_ta[i] = w_ea[i*DSP_A_U +: DSP_A_U+1];
        end else begin : g_low
            assign w_ta[i] = {1'b0, w_ea[i*DSP_A_U +: DSP_A_U]};
        end
    end
    for (genvar j = 0; j < N_B; j++) begin : g_tile_b
        if (j == N_B - 1) begin : g_top
            assign w_tb[j] = w_eb[j*DSP_B_U +: DSP_B_U+1];
        end else begin : g_low
            assign w_tb[j] = {1'b0, w_eb[j*DSP_B_U +: DSP_B_U]};
        end
    end

    // ------------------------------------------------------------------
    // Partial products (level 0) and adder tree (levels 1..D)
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int CNT = lvl_cnt(l);
        logic [W-1:0] w_node [CNT];

        if (l == 0) begin : g_pp
            for (genvar i = 0; i < N_A; i++) begin : g_i
                for (genvar j = 0; j < N_B; j++) begin : g_j
                    logic signed [PW-1:0] w_xa;
                    logic signed [PW-1:0] w_xb;
                    logic signed [PW-1:0] w_p;
                    logic        [W-1:0]  w_sh;
                    assign w_xa = PW'($signed(w_ta[i]));
                    assign w_xb = PW'($signed(w_tb[j]));
                    assign w_p  = w_xa * w_xb;
                    // Modulo-2^W arithmetic keeps the signed correction exact.
                    assign w_sh = W'(w_p) << (i * DSP_A_U + j * DSP_B_U);
                    if (FF_MUL != 0) begin : g_ff_mul
                        logic [W-1:0] pp_q;
                        // Register each shifted partial product at the DSP output.
                        always_ff @(posedge clk) begin
                            if (w_take[FF_IN]) pp_q <= w_sh;
                        end
                        assign w_node[i*N_B + j] = pp_q;
                    end else begin : g_no_ff_mul
                        assign w_node[i*N_B + j] = w_sh;
                    end
                end
            end
        end else begin : g_add_lvl
            localparam int PCNT = lvl_cnt(l - 1);
            localparam int STG  = FF_IN + FF_MUL + (l + ADD_LVL_PER_FF - 1) / ADD_LVL_PER_FF - 1;
            localparam bit REG  = ((l % ADD_LVL_PER_FF) == 0) || (l == D);
            for (genvar n = 0; n < CNT; n++) begin : g_node
                logic [W-1:0] w_sum;
                if (2*n + 1 < PCNT) begin : g_add
                    assign w_sum = g_lvl[l-1].w_node[2*n] + g_lvl[l-1].w_node[2*n+1];
                end else begin : g_pass
                    assign w_sum = g_lvl[l-1].w_node[2*n];
                end
                if (l == D) begin : g_out
                    logic [W-1:0] sum_q;
                    // Output register: cleared by reset, held while stalled.
                    always_ff @(posedge clk) begin
                        if (!rst)           sum_q <= '0;
                        else if (w_take[STG]) sum_q <= w_sum;
                    end
                    assign w_node[n] = sum_q;
                end else if (REG) begin : g_reg
                    logic [W-1:0] sum_q;
                    // Intermediate tree register, advances with its stage.
                    always_ff @(posedge clk) begin
                        if (w_take[STG]) sum_q <= w_sum;
                    end
                    assign w_node[n] = sum_q;
                end else begin : g_comb
                    assign w_node[n] = w_sum;
                end
            end
        end
    end

    assign C = g_lvl[D].w_node[0];

endmodule
`default_nettype wire

// File: tb/tb_intmul_tiled_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_intmul_tiled_pipe
//  Purpose  : Scoreboard bench for intmul_tiled_pipe with default parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intmul_tiled_pipe;

    localparam int LOGA  = 34;
    localparam int LOGB  = 43;
    localparam int TAG_W = 8;
    localparam int W     = LOGA + LOGB;
    localparam int S     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [LOGA-1:0]  A = '0;
    logic [LOGB-1:0]  B = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [W-1:0]     C;
    logic [TAG_W-1:0] out_tag;
    logic             cur_sgn = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]     q_c [$];
    logic [TAG_W-1:0] q_t [$];

    always #5 clk = ~clk;

    intmul_tiled_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .in_tag    (in_tag),
`ifdef INTMUL_SIGNED_EN
        .sgn       (cur_sgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .out_tag   (out_tag)
    );

    function automatic logic [W-1:0] ref_mul(input logic [LOGA-1:0] a,
                                             input logic [LOGB-1:0] b,
                                             input logic s);
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        xa = s ? {{LOGB{a[LOGA-1]}}, a} : {{LOGB{1'b0}}, a};
        xb = s ? {{LOGA{b[LOGB-1]}}, b} : {{LOGA{1'b0}}, b};
        return xa * xb;
    endfunction

    function automatic logic [LOGA-1:0] rnd_a();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[LOGA-1:0];
    endfunction

    function automatic logic [LOGB-1:0] rnd_b();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[LOGB-1:0];
    endfunction

    // One cycle: drive at the falling edge, observe 1 ns later, push accepted ops.
    task automatic drive_cycle(input logic iv, input logic [LOGA-1:0] a,
                               input logic [LOGB-1:0] b, input logic [TAG_W-1:0] t,
                               input logic ordy, output logic acc, output logic fire,
                               output logic [W-1:0] c_o, output logic [TAG_W-1:0] t_o);
        @(negedge clk);
        in_valid  = iv;
        A         = a;
        B         = b;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc  = in_valid & in_ready;
        fire = out_valid & out_ready;
        c_o  = C;
        t_o  = out_tag;
        if (acc) begin
            q_c.push_back(ref_mul(a, b, cur_sgn));
            q_t.push_back(t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
        total++; if (C !== '0)          begin bad++; $display("FAIL reset_C got %h need 0", C); end
        total++; if (out_tag !== '0)    begin bad++; $display("FAIL reset_out_tag got %h need 0", out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
    endtask

    task automatic test_single();
        logic acc, fire;
        logic [W-1:0] c;
        logic [TAG_W-1:0] t;
        logic [W-1:0] ce;
        int fire_at;
        ce = '0 - (W'(1) << 43) - (W'(1) << 34) + W'(1);
        fire_at = -1;
        drive_cycle(1'b1, '1, '1, 8'h5A, 1'b1, acc, fire, c, t);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept got %b need 1", acc); end
        for (int n = 1; n <= 20; n++) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b1, acc, fire, c, t);
            if (fire) begin
                fire_at = n;
                break;
            end
        end
        total++; if (fire_at != S)    begin bad++; $display("FAIL single_latency got %0d need %0d", fire_at, S); end
        total++; if (c !== ce)        begin bad++; $display("FAIL single_C got %h need %h", c, ce); end
        total++; if (t !== 8'h5A)     begin bad++; $display("FAIL single_tag got %h need 5a", t); end
        q_c.delete();
        q_t.delete();
    endtask

    task automatic test_back_to_back();
        logic acc, fire;
        logic [W-1:0] c, ec;
        logic [TAG_W-1:0] t, et;
        int first, last, nout;
        first = -1; last = -1; nout = 0;
        for (int n = 0; n < 64 + 20; n++) begin
            drive_cycle(n < 64, rnd_a(), rnd_b(), 8'($urandom()), 1'b1, acc, fire, c, t);
            if (n < 64) begin
                total++; if (acc !== 1'b1) begin bad++; $display("FAIL b2b_accept op %0d got %b need 1", n, acc); end
            end
            if (fire) begin
                if (first < 0) first = n;
                last = n;
                nout++;
                total++;
                if (q_c.size() == 0) begin
                    bad++; $display("FAIL b2b_extra got C=%h need no output", c);
                end else begin
                    ec = q_c.pop_front(); et = q_t.pop_front();
                    if (c !== ec || t !== et) begin
                        bad++; $display("FAIL b2b_data got C=%h tag=%h need C=%h tag=%h", c, t, ec, et);
                    end
                end
            end
        end
        total++;
        if (nout != 64 || last - first != 63) begin
            bad++; $display("FAIL b2b_rate got %0d results over %0d cycles need 64 over 63", nout, last - first);
        end
    endtask

    task automatic test_backpressure();
        logic acc, fire;
        logic [W-1:0] c, ec, c_hold;
        logic [TAG_W-1:0] t, et, t_hold;
        logic [LOGA-1:0] a_s [6];
        logic [LOGB-1:0] b_s [6];
        int k, nacc;
        k = 0; nacc = 0;
        for (int i = 0; i < 6; i++) begin
            a_s[i] = rnd_a();
            b_s[i] = rnd_b();
        end
        for (int n = 0; n < 6; n++) begin
            drive_cycle(1'b1, a_s[k], b_s[k], 8'(8'h10 + k), 1'b0, acc, fire, c, t);
            if (acc) begin k++; nacc++; end
            if (n >= 4) begin
                total++; if (acc !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle %0d got accept need stall", n); end
            end
        end
        total++; if (nacc != S) begin bad++; $display("FAIL bp_accepted got %0d need %0d", nacc, S); end
        c_hold = C;
        t_hold = out_tag;
        total++;
        if (q_c.size() == 0 || out_valid !== 1'b1 || c_hold !== q_c[0] || t_hold !== q_t[0]) begin
            bad++; $display("FAIL bp_head got valid=%b C=%h tag=%h", out_valid, c_hold, t_hold);
        end
        for (int n = 0; n < 3; n++) begin
            drive_cycle(1'b1, a_s[k], b_s[k], 8'(8'h10 + k), 1'b0, acc, fire, c, t);
            total++;
            if (c !== c_hold || t !== t_hold || acc !== 1'b0) begin
                bad++; $display("FAIL bp_hold got C=%h tag=%h acc=%b need C=%h tag=%h acc=0", c, t, acc, c_hold, t_hold);
            end
        end
        for (int n = 0; n < 30 && (k < 6 || q_c.size() != 0); n++) begin
            drive_cycle(k < 6, a_s[k % 6], b_s[k % 6], 8'(8'h10 + k), 1'b1, acc, fire, c, t);
            if (n == 0) begin
                total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_release_accept got %b need 1", acc); end
            end
            if (acc) k++;
            if (fire) begin
                total++;
                if (q_c.size() == 0) begin
                    bad++; $display("FAIL bp_extra got C=%h need no output", c);
                end else begin
                    ec = q_c.pop_front(); et = q_t.pop_front();
                    if (c !== ec || t !== et) begin
                        bad++; $display("FAIL bp_data got C=%h tag=%h need C=%h tag=%h", c, t, ec, et);
                    end
                end
            end
        end
        total++; if (k != 6 || q_c.size() != 0) begin bad++; $display("FAIL bp_drain got sent=%0d left=%0d need 6 and 0", k, q_c.size()); end
    endtask

    task automatic test_random();
        logic acc, fire;
        logic [W-1:0] c, ec;
        logic [TAG_W-1:0] t, et;
        int sent, got;
        sent = 0; got = 0;
        for (int n = 0; n < 20000 && (sent < 2000 || q_c.size() != 0); n++) begin
            drive_cycle((sent < 2000) && 1'($urandom_range(0, 1)), rnd_a(), rnd_b(), 8'(sent),
                        1'($urandom_range(0, 1)), acc, fire, c, t);
            if (acc) sent++;
            if (fire) begin
                got++;
                total++;
                if (q_c.size() == 0) begin
                    bad++; $display("FAIL rnd_extra got C=%h tag=%h need no output", c, t);
                end else begin
                    ec = q_c.pop_front(); et = q_t.pop_front();
                    if (c !== ec || t !== et) begin
                        bad++; $display("FAIL rnd_data got C=%h tag=%h need C=%h tag=%h", c, t, ec, et);
                    end
                end
            end
        end
        total++; if (got != 2000 || q_c.size() != 0) begin bad++; $display("FAIL rnd_count got %0d left %0d need 2000 and 0", got, q_c.size()); end
    endtask

    task automatic test_flush();
        logic acc, fire;
        logic [W-1:0] c;
        logic [TAG_W-1:0] t;
        int seen;
        seen = 0;
        for (int n = 0; n < 3; n++) begin
            drive_cycle(1'b1, rnd_a(), rnd_b(), 8'(8'hE0 + n), 1'b1, acc, fire, c, t);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL flush_accept op %0d got %b need 1", n, acc); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got %b need 0", out_valid); end
        total++; if (C !== '0)          begin bad++; $display("FAIL flush_C got %h need 0", C); end
        total++; if (out_tag !== '0)    begin bad++; $display("FAIL flush_out_tag got %h need 0", out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got %b need 1", in_ready); end
        q_c.delete();
        q_t.delete();
        for (int n = 0; n < 20; n++) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b1, acc, fire, c, t);
            if (fire) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_leak got %0d results need 0", seen); end
    endtask

`ifdef INTMUL_SIGNED_EN
    task automatic test_signed();
        logic acc, fire;
        logic [W-1:0] c;
        logic [TAG_W-1:0] t;
        logic [W-1:0] exp_c [4];
        logic [LOGA-1:0] a_s [4];
        logic [LOGB-1:0] b_s [4];
        logic s_s [4];
        int nout;
        nout = 0;
        a_s[0] = '1;                b_s[0] = '1;              s_s[0] = 1'b1;
        a_s[1] = LOGA'(1) << 33;    b_s[1] = {1'b0, {42{1'b1}}}; s_s[1] = 1'b1;
        a_s[2] = '1;                b_s[2] = '1;              s_s[2] = 1'b0;
        a_s[3] = LOGA'(1) << 33;    b_s[3] = {1'b0, {42{1'b1}}}; s_s[3] = 1'b0;
        exp_c[0] = W'(1);
        exp_c[1] = '0 - (W'(1) << 75) + (W'(1) << 33);
        exp_c[2] = '0 - (W'(1) << 43) - (W'(1) << 34) + W'(1);
        exp_c[3] = (W'(1) << 75) - (W'(1) << 33);
        for (int n = 0; n < 4 + 20; n++) begin
            cur_sgn = (n < 4) ? s_s[n] : 1'b0;
            drive_cycle(n < 4, a_s[n % 4], b_s[n % 4], 8'(8'hC0 + n), 1'b1, acc, fire, c, t);
            if (fire && nout < 4) begin
                total++;
                if (c !== exp_c[nout] || t !== 8'(8'hC0 + nout)) begin
                    bad++; $display("FAIL signed_op%0d got C=%h tag=%h need C=%h", nout, c, t, exp_c[nout]);
                end
                nout++;
            end
        end
        total++; if (nout != 4) begin bad++; $display("FAIL signed_count got %0d need 4", nout); end
        cur_sgn = 1'b0;
        q_c.delete();
        q_t.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_flush();
`ifdef INTMUL_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
